// File: rtl/mm_input_cond.sv
// Input conditioner: 2-flop synchronizer plus per-bit debounce for {JOY_N, SW_N}.
// Define MM_INPUT_DEBOUNCE_EN to build the debounce counters; otherwise out follows s2 directly.
module mm_input_cond #(
  parameter int DB_CYCLES = 1190,
  parameter int CNT_W     = 16
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic [7:0] JOY_N,
  input  logic [7:0] SW_N,
  output logic [7:0] PA,
  output logic [7:0] PB,
  output logic       CHG
);

  // A zero setting behaves like a one-cycle qualification window.
  localparam int              DB_EFF = (DB_CYCLES < 1) ? 1 : DB_CYCLES;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DB_EFF - 1);

  logic [15:0] raw;
  logic [15:0] s1_reg;
  logic [15:0] s2_reg;
  logic [15:0] out_reg;
  logic [15:0] out_next;
  logic        chg_reg;

  assign raw = {JOY_N, SW_N};

  always_ff @(posedge CLK) begin
    if (RES) begin
      s1_reg <= '1;
      s2_reg <= '1;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
    end
  end

`ifdef MM_INPUT_DEBOUNCE_EN
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_db
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             differ;
      logic             at_limit;

      assign differ   = s2_reg[gi] ^ out_reg[gi];
      assign at_limit = (cnt_reg == LIMIT);
      // Any cycle where s2 agrees with out drops the count, so short glitches never accumulate.
      assign out_next[gi] = (differ && at_limit) ? s2_reg[gi] : out_reg[gi];
      assign cnt_next     = (differ && !at_limit) ? cnt_reg + 1'b1 : '0;

      always_ff @(posedge CLK) begin
        if (RES) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate
`else
  logic [CNT_W-1:0] unused_limit;
  assign unused_limit = LIMIT;
  assign out_next     = s2_reg;
`endif

  // CHG is registered alongside out so it marks the first cycle the new value is visible.
  always_ff @(posedge CLK) begin
    if (RES) begin
      out_reg <= '1;
      chg_reg <= 1'b0;
    end else begin
      out_reg <= out_next;
      chg_reg <= |(out_next ^ out_reg);
    end
  end

  assign PA  = out_reg[15:8];
  assign PB  = out_reg[7:0];
  assign CHG = chg_reg;

endmodule

// File: tb/tb_mm_input_cond.sv
// Directed self-checking bench for mm_input_cond (DB_CYCLES=4; passthrough timing when debounce is not built).
module tb_mm_input_cond;

  localparam int DB = 4;
`ifdef MM_INPUT_DEBOUNCE_EN
  localparam int L = DB;
`else
  localparam int L = 1;
`endif

  logic       CLK;
  logic       RES;
  logic [7:0] JOY_N;
  logic [7:0] SW_N;
  logic [7:0] PA;
  logic [7:0] PB;
  logic       CHG;

  int total;
  int bad;

  mm_input_cond #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .CLK  (CLK),
    .RES  (RES),
    .JOY_N(JOY_N),
    .SW_N (SW_N),
    .PA   (PA),
    .PB   (PB),
    .CHG  (CHG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge and settle; inputs driven after this are sampled on the next edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset;
    RES = 1'b1; JOY_N = 8'h00; SW_N = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      total++;
      if (PA !== 8'hFF || PB !== 8'hFF || CHG !== 1'b0) begin
        bad++; $display("FAIL reset_hold: PA=%h PB=%h CHG=%b want FF FF 0", PA, PB, CHG);
      end
    end
    RES = 1'b0;
    tick(L + 1);
    total++;
    if (PA !== 8'hFF) begin bad++; $display("FAIL reset_early: PA=%h want FF", PA); end
    tick(1);
    total++;
    if (PA !== 8'h00 || CHG !== 1'b1) begin
      bad++; $display("FAIL reset_release: PA=%h CHG=%b want 00 1", PA, CHG);
    end
    tick(1);
    total++;
    if (CHG !== 1'b0) begin bad++; $display("FAIL reset_chg_end: CHG=%b want 0", CHG); end
    JOY_N = 8'hFF;
    tick(L + 4);
    total++;
    if (PA !== 8'hFF) begin bad++; $display("FAIL reset_restore: PA=%h want FF", PA); end
    $display("reset: PA=%h PB=%h", PA, PB);
  endtask

  task automatic test_clean_press;
    SW_N = 8'hFE;
    tick(L + 1);
    total++;
    if (PB !== 8'hFF || CHG !== 1'b0) begin
      bad++; $display("FAIL press_early: PB=%h CHG=%b want FF 0", PB, CHG);
    end
    tick(1);
    total++;
    if (PB !== 8'hFE || PA !== 8'hFF || CHG !== 1'b1) begin
      bad++; $display("FAIL press_update: PA=%h PB=%h CHG=%b want FF FE 1", PA, PB, CHG);
    end
    tick(1);
    total++;
    if (CHG !== 1'b0 || PB !== 8'hFE) begin
      bad++; $display("FAIL press_pulse_end: PB=%h CHG=%b want FE 0", PB, CHG);
    end
    SW_N = 8'hFF;
    tick(L + 4);
    total++;
    if (PB !== 8'hFF) begin bad++; $display("FAIL press_release: PB=%h want FF", PB); end
    $display("clean_press: PB=%h", PB);
  endtask

  task automatic test_bounce;
`ifdef MM_INPUT_DEBOUNCE_EN
    for (int c = 0; c < 20; c++) begin
      JOY_N = ((c / 2) % 2 == 0) ? 8'h7F : 8'hFF;
      tick(1);
      total++;
      if (PA !== 8'hFF || CHG !== 1'b0) begin
        bad++; $display("FAIL bounce_hold: cycle=%0d PA=%h CHG=%b want FF 0", c, PA, CHG);
      end
    end
    JOY_N = 8'h7F;
    tick(L + 1);
    total++;
    if (PA !== 8'hFF) begin bad++; $display("FAIL bounce_early: PA=%h want FF", PA); end
    tick(1);
    total++;
    if (PA !== 8'h7F || CHG !== 1'b1) begin
      bad++; $display("FAIL bounce_settle: PA=%h CHG=%b want 7F 1", PA, CHG);
    end
    JOY_N = 8'hFF;
    tick(L + 4);
    total++;
    if (PA !== 8'hFF) begin bad++; $display("FAIL bounce_release: PA=%h want FF", PA); end
    $display("bounce: PA=%h", PA);
`endif
  endtask

  task automatic test_glitch;
    SW_N = 8'hFE;
    tick(1);
    SW_N = 8'hFF;
`ifdef MM_INPUT_DEBOUNCE_EN
    for (int k = 0; k < L + 4; k++) begin
      tick(1);
      total++;
      if (PB !== 8'hFF || CHG !== 1'b0) begin
        bad++; $display("FAIL glitch_reject: PB=%h CHG=%b want FF 0", PB, CHG);
      end
    end
`else
    tick(1);
    total++;
    if (PB !== 8'hFF || CHG !== 1'b0) begin
      bad++; $display("FAIL glitch_early: PB=%h CHG=%b want FF 0", PB, CHG);
    end
    tick(1);
    total++;
    if (PB !== 8'hFE || CHG !== 1'b1) begin
      bad++; $display("FAIL glitch_low: PB=%h CHG=%b want FE 1", PB, CHG);
    end
    tick(1);
    total++;
    if (PB !== 8'hFF || CHG !== 1'b1) begin
      bad++; $display("FAIL glitch_high: PB=%h CHG=%b want FF 1", PB, CHG);
    end
    tick(1);
    total++;
    if (CHG !== 1'b0) begin bad++; $display("FAIL glitch_chg_end: CHG=%b want 0", CHG); end
`endif
    $display("glitch: PB=%h", PB);
  endtask

  task automatic test_simultaneous;
    JOY_N = 8'hFE; SW_N = 8'hF7;
    tick(L + 1);
    total++;
    if (PA !== 8'hFF || PB !== 8'hFF || CHG !== 1'b0) begin
      bad++; $display("FAIL simul_early: PA=%h PB=%h CHG=%b want FF FF 0", PA, PB, CHG);
    end
    tick(1);
    total++;
    if (PA !== 8'hFE || PB !== 8'hF7 || CHG !== 1'b1) begin
      bad++; $display("FAIL simul_update: PA=%h PB=%h CHG=%b want FE F7 1", PA, PB, CHG);
    end
    tick(1);
    total++;
    if (CHG !== 1'b0) begin bad++; $display("FAIL simul_single_pulse: CHG=%b want 0", CHG); end
    JOY_N = 8'hFF; SW_N = 8'hFF;
    tick(L + 4);
    $display("simultaneous: PA=%h PB=%h", PA, PB);
  endtask

  task automatic test_reset_mid;
    JOY_N = 8'hEF;
    tick(3);
    RES = 1'b1;
    tick(1);
    total++;
    if (PA !== 8'hFF || CHG !== 1'b0) begin
      bad++; $display("FAIL midreset_out: PA=%h CHG=%b want FF 0", PA, CHG);
    end
    tick(1);
    RES = 1'b0;
    tick(L + 1);
    total++;
    if (PA !== 8'hFF) begin bad++; $display("FAIL midreset_early: PA=%h want FF", PA); end
    tick(1);
    total++;
    if (PA !== 8'hEF || CHG !== 1'b1) begin
      bad++; $display("FAIL midreset_restart: PA=%h CHG=%b want EF 1", PA, CHG);
    end
    JOY_N = 8'hFF;
    tick(L + 4);
    $display("reset_mid: PA=%h", PA);
  endtask

  task automatic test_back_to_back;
    JOY_N = 8'hFE;
    tick(1);
    JOY_N = 8'hFC;
    tick(L + 1);
    total++;
    if (PA !== 8'hFE || CHG !== 1'b1) begin
      bad++; $display("FAIL b2b_first: PA=%h CHG=%b want FE 1", PA, CHG);
    end
    tick(1);
    total++;
    if (PA !== 8'hFC || CHG !== 1'b1) begin
      bad++; $display("FAIL b2b_second: PA=%h CHG=%b want FC 1", PA, CHG);
    end
    tick(1);
    total++;
    if (CHG !== 1'b0) begin bad++; $display("FAIL b2b_chg_end: CHG=%b want 0", CHG); end
    JOY_N = 8'hFF;
    tick(L + 4);
    $display("back_to_back: PA=%h", PA);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RES   = 1'b1;
    JOY_N = 8'hFF;
    SW_N  = 8'hFF;
    tick(1);
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_input_cond.md
# mm_input_cond

Input conditioner for the console's player and front-panel controls. It sits directly upstream of the RIOT and drives the RIOT's `PA_IN` and `PB_IN` peripheral inputs. Each raw, asynchronous, active-low line is double-flop synchronized and then debounced per bit, so the RIOT never sees metastable or bouncing values. It also emits a one-cycle change pulse for system-level wake/trace logic.

## Interface
- `DB_CYCLES`, default 1190: consecutive cycles a new level must persist before it is accepted (about 1 ms at 1.19 MHz). Legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 16: width of each per-bit debounce counter.

Ports:
- `CLK`  in  1  system clock; single clock domain.
- `RES`  in  1  reset, synchronous, active-high.
- `JOY_N`  in  8  raw joystick lines, asynchronous, active-low. Bits 7:4 are P0 right/left/down/up; bits 3:0 are P1 right/left/down/up.
- `SW_N`  in  8  raw console switch/difficulty lines, asynchronous, active-low.
- `PA`  out  8  debounced `JOY_N`; connects to RIOT `PA_IN`.
- `PB`  out  8  debounced `SW_N`; connects to RIOT `PB_IN`.
- `CHG`  out  1  one-cycle pulse when any bit of `PA` or `PB` changes.

## Operation
- Bit ordering: the 16 lines are treated identically and independently, as bit vector {`JOY_N`,`SW_N`}.
- Synchronizer: two flops per bit, s1 then s2. Both reset to 1.
- Debounce, per bit, on every `CLK` edge with `RES`=0:
  - s2 == out: cnt <= 0.
  - s2 != out and cnt == `DB_CYCLES`-1: out <= s2, cnt <= 0.
  - s2 != out otherwise: cnt <= cnt+1.
- Glitch rejection: a differing level that lasts fewer than `DB_CYCLES` cycles at s2 returns cnt to 0 and out is unchanged. Counting restarts from 0 on the next differing cycle.
- Counter width: cnt never exceeds `DB_CYCLES`-1, so it cannot wrap. `DB_CYCLES`=0 is treated as 1.
- `CHG`: registered. It is high for exactly the cycle in which any out bit first shows its new value. Multiple bits updating on the same edge produce a single pulse. Back-to-back updates on consecutive edges keep `CHG` high for both cycles.
- Reset values: s1=s2=1; all cnt=0; `PA`=8'hFF; `PB`=8'hFF (all released); `CHG`=0.
- Reset mid-operation: a reset asserted while a count is in progress discards the count. Outputs return to 8'hFF on the edge `RES` is sampled high.
- No combinational path from inputs to outputs.

## Timing
- A raw level is first sampled into s1 at edge E.
- If that level holds, out changes at edge E+1+`DB_CYCLES`, and `CHG` is high in the following cycle.
- Example: `DB_CYCLES`=1 gives out at E+2, so first visible after 3 register stages including the output register.
- Inputs must hold stable for at least `DB_CYCLES`+2 cycles to be guaranteed propagated.
- The RIOT samples `PA`/`PB` with no further synchronization. The outputs are glitch-free registered values.

## Configuration
- Macro: `MM_INPUT_DEBOUNCE_EN`.
- Defined: debounce counters are present and behave as in Operation.
- Undefined: counters are omitted and `DB_CYCLES` is ignored. out <= s2 every cycle, giving a fixed latency of 3 edges from the first s1 sample to out. `CHG` still pulses on any change.
- Reset values are identical in both builds.

## Test plan
All scenarios use `DB_CYCLES`=4 with the macro defined unless noted.
- Reset: hold `RES`=1 for 2 cycles with `JOY_N`=8'h00 → `PA`=8'hFF, `PB`=8'hFF, `CHG`=0 throughout. After release, `PA` becomes 8'h00 exactly 5 edges after the first s1 sample.
- Clean press: `SW_N` 8'hFF→8'hFE held → `PB`=8'hFE at edge E+5, `CHG` pulses once, other bits are unaffected.
- Bounce: `JOY_N[7]` toggles 0/1 every 2 cycles for 20 cycles, then holds 0 → no `PA` change during the bouncing; `PA[7]`=0 exactly 4 cycles after the level settles at s2.
- Simultaneous: `JOY_N[0]` and `SW_N[3]` fall on the same cycle → both outputs update on the same edge, and `CHG` is a single 1-cycle pulse.
- Reset mid-count: press `JOY_N[4]`, assert `RES` 2 cycles into the count → `PA[4]`=1. After release, the full 5-edge latency restarts.
- Macro undefined: 1-cycle glitch on `SW_N[0]` → `PB[0]` pulses low for exactly 1 cycle after 3 edges, and `CHG` pulses twice.
